// File: rtl/uart_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_mem_loader_pkg
//   Shared definitions for the UART memory loader command parser. It provides
//   the ASCII command and response characters, the parser state encoding, and
//   a hex-digit decoder used by the address entry state.
// -----------------------------------------------------------------------------
package uart_mem_loader_pkg;

    // Command characters; upper and lower case are both accepted
    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_A_LC = 8'h61;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_R_LC = 8'h72;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;

    // Response characters
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_Q    = 8'h3F;

    // Whitespace that is silently ignored in IDLE
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] SP      = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD_WAIT,
        ST_TX
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_nib_t;

    // Decode one ASCII hex digit (0-9, A-F, a-f); valid=0 for anything else
    function automatic hex_nib_t hex_to_nibble(input logic [7:0] ch);
        hex_nib_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            r.nibble = 4'(ch - 8'h30);
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            r.nibble = 4'(ch - 8'h37);
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            r.nibble = 4'(ch - 8'h57);
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// -----------------------------------------------------------------------------
// uart_mem_loader_if
//   Bundles the three links of the loader: receive strobe from uart_rx,
//   transmit handshake to uart_tx, and the 1-bit synchronous-read memory port.
//   master: the loader (drives tx, memory address/write, overrun)
//   slave : the surroundings (drive rx bytes, tx_wait, memory read data)
//   Signals:
//     rx_data/rx_valid   received byte and its one-cycle strobe
//     tx_data/tx_we      byte to send, request held until accepted
//     tx_wait            transmitter busy
//     mem_addr/mem_we/mem_wdata/mem_rdata  memory port
//     overrun            sticky flag: a byte arrived while busy
// -----------------------------------------------------------------------------
interface uart_mem_loader_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_we;
    logic              tx_wait;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;
    logic              overrun;

    modport master (
        input  rx_data, rx_valid, tx_wait, mem_rdata,
        output tx_data, tx_we, mem_addr, mem_we, mem_wdata, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_wait, mem_rdata,
        input  tx_data, tx_we, mem_addr, mem_we, mem_wdata, overrun
    );
endinterface

// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
//   ASCII command parser between uart_rx and uart_tx that loads and inspects a
//   1-bit-wide synchronous-read memory. Commands:
//     A/a + ADDR_W/4 hex digits : set address pointer, answers 'K'
//     0 / 1                     : write bit at pointer, pointer+1, echoes bit
//                                 (silent when ECHO_WRITES=0)
//     R/r                       : read bit at pointer, pointer+1, answers '0'/'1'
//     CR, LF, space             : ignored
//     anything else             : answers '?'
//   Ports:
//     clk     clock
//     resetn  synchronous, active-low reset
//     bus     uart_mem_loader_if.master (rx, tx handshake, memory, overrun)
//   Parameters:
//     ADDR_W       memory address width, multiple of 4 in 4..32
//     ECHO_WRITES  1: echo written bit, 0: writes produce no tx byte
// -----------------------------------------------------------------------------
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter bit          ECHO_WRITES = 1'b1
) (
    input logic               clk,
    input logic               resetn,
    uart_mem_loader_if.master bus
);

    localparam int unsigned NDIGITS = ADDR_W / 4;

    state_e            state_q;
    logic [ADDR_W-1:0] shift_q;
    logic [3:0]        digit_cnt_q;
    logic [7:0]        tx_data_q;
    logic              tx_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic              mem_wdata_q;
    logic              overrun_q;

    hex_nib_t          hex;
    logic [ADDR_W-1:0] shift_next;
    logic              last_digit;
    logic              is_addr_cmd;
    logic              is_read_cmd;
    logic              is_bit_cmd;
    logic              is_space;

    assign hex         = hex_to_nibble(bus.rx_data);
    assign shift_next  = (shift_q << 4) | ADDR_W'(hex.nibble);
    assign last_digit  = (digit_cnt_q == 4'(NDIGITS - 1));
    assign is_addr_cmd = (bus.rx_data == CH_A) || (bus.rx_data == CH_A_LC);
    assign is_read_cmd = (bus.rx_data == CH_R) || (bus.rx_data == CH_R_LC);
    assign is_bit_cmd  = (bus.rx_data == CH_0) || (bus.rx_data == CH_1);
    assign is_space    = (bus.rx_data == CR) || (bus.rx_data == LF) || (bus.rx_data == SP);

    // NOTE: the reset branch sits inside the clocked block with only clk in the
    // sensitivity list, which makes it synchronous; all state uses <= so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            digit_cnt_q <= 4'd0;
            tx_data_q   <= 8'h00;
            tx_we_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // The write strobe lasts one cycle; the pointer advances right
            // after it so the write lands at the old address.
            mem_we_q <= 1'b0;
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        if (is_addr_cmd) begin
                            state_q     <= ST_ADDR;
                            digit_cnt_q <= 4'd0;
                            shift_q     <= '0;
                        end else if (is_bit_cmd) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.rx_data[0];
                            if (ECHO_WRITES) begin
                                tx_data_q <= bus.rx_data;
                                tx_we_q   <= 1'b1;
                                state_q   <= ST_TX;
                            end
                        end else if (is_read_cmd) begin
                            // Pointer is held this cycle so the memory samples it
                            state_q <= ST_RD_WAIT;
                        end else if (is_space) begin
                            state_q <= ST_IDLE;
                        end else begin
                            tx_data_q <= CH_Q;
                            tx_we_q   <= 1'b1;
                            state_q   <= ST_TX;
                        end
                    end
                end

                ST_ADDR: begin
                    if (bus.rx_valid) begin
                        if (hex.valid) begin
                            shift_q     <= shift_next;
                            digit_cnt_q <= digit_cnt_q + 4'd1;
                            if (last_digit) begin
                                mem_addr_q <= shift_next;
                                tx_data_q  <= CH_K;
                                tx_we_q    <= 1'b1;
                                state_q    <= ST_TX;
                            end
                        end else begin
                            tx_data_q <= CH_Q;
                            tx_we_q   <= 1'b1;
                            state_q   <= ST_TX;
                        end
                    end
                end

                ST_RD_WAIT: begin
                    if (bus.rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    tx_data_q  <= bus.mem_rdata ? CH_1 : CH_0;
                    tx_we_q    <= 1'b1;
                    mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    state_q    <= ST_TX;
                end

                ST_TX: begin
                    if (bus.rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (!bus.tx_wait) begin
                        tx_we_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_we     = tx_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.overrun   = overrun_q;

endmodule
